hilo_mult_seq: RTL



---
 rtl/hilo_mult_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/hilo_mult_seq.sv
// HI/LO register pair with a fixed-latency sequencer in front of an external combinational multiplier.
// Multiply results land MULT_LATENCY cycles after acceptance; MTHI/MTLO complete in one cycle. START is ignored while BUSY.
module hilo_mult_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] PROD_HI,
  input  logic [DATA_WIDTH-1:0] PROD_LO,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  output logic                  SIGNED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MULT_LATENCY - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_op_a, w_op_a_nxt;
  logic [DATA_WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic                  r_signed, w_signed_nxt;
  logic                  r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0] r_hi, w_hi_nxt;
  logic [DATA_WIDTH-1:0] r_lo, w_lo_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op_a   <= w_op_a_nxt;
      r_op_b   <= w_op_b_nxt;
      r_signed <= w_signed_nxt;
      r_done   <= w_done_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_a_nxt   = r_op_a;
    w_op_b_nxt   = r_op_b;
    w_signed_nxt = r_signed;
    w_done_nxt   = 1'b0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          if (!OP[1]) begin
            w_op_a_nxt   = A;
            w_op_b_nxt   = B;
            w_signed_nxt = ~OP[0];
            w_cnt_nxt    = LAT_M1;
            w_state_nxt  = ST_WAIT;
          end else begin
            if (OP[0]) w_lo_nxt = A;
            else       w_hi_nxt = A;
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Operands stay frozen here so the array sees stable inputs while settling.
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_hi_nxt    = PROD_HI;
          w_lo_nxt    = PROD_LO;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign OP_A   = r_op_a;
  assign OP_B   = r_op_b;
  assign SIGNED = r_signed;
  assign BUSY   = (r_state == ST_WAIT);
  assign DONE   = r_done;
  assign HI     = r_hi;
  assign LO     = r_lo;

endmodule
